// File: rtl/countdown_timer_pkg.sv
// Shared types, constants and helpers for the MM:SS.cc countdown timer.
// Digits are BCD; segment patterns are active-low {g,f,e,d,c,b,a}.
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } timer_state_t;

   typedef logic [3:0] bcd_digit_t;
   typedef logic [6:0] seg7_t;

   localparam int TICK_DIV_50M    = 500000;
   localparam int BLINK_TICKS_DEF = 25;

   function automatic bcd_digit_t clamp_digit(bcd_digit_t d, bcd_digit_t max_val);
      return (d > max_val) ? max_val : d;
   endfunction

   function automatic seg7_t sevenseg(bcd_digit_t d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Key/preset inputs and display/LED outputs of the countdown timer.
// master = board top (keys, switches); slave = countdown_timer.
interface countdown_timer_if;
   import countdown_timer_pkg::*;

   logic       key_start_pause;
   logic       key_load;
   logic [7:0] preset_min;
   logic [7:0] preset_sec;
   seg7_t      hex5, hex4, hex3, hex2, hex1, hex0;
   logic       led_running;
   logic       led_done;
   logic       done_pulse;

   modport master (
      output key_start_pause, key_load, preset_min, preset_sec,
      input  hex5, hex4, hex3, hex2, hex1, hex0, led_running, led_done, done_pulse
   );

   modport slave (
      input  key_start_pause, key_load, preset_min, preset_sec,
      output hex5, hex4, hex3, hex2, hex1, hex0, led_running, led_done, done_pulse
   );

endinterface

// File: rtl/countdown_timer_bcd_digit_down.sv
// One BCD down-counting digit; wraps 0 -> max_val and raises borrow so the
// next-higher digit decrements on the same tick.
module bcd_digit_down
   import countdown_timer_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic       key_reset,
   input  logic       load,
   input  bcd_digit_t load_val,
   input  logic       dec,
   input  bcd_digit_t max_val,
   output bcd_digit_t digit,
   output logic       borrow
);

   assign borrow = dec && (digit == 4'd0);

   // NOTE: non-blocking assignment so every digit in the chain samples pre-edge values.
   always_ff @(posedge CLOCK_50) begin
      if (key_reset) begin
         digit <= '0;
      end else if (load) begin
         digit <= load_val;
      end else if (dec) begin
         digit <= borrow ? max_val : digit - 4'd1;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: presettable MM:SS, decrements in 10 ms ticks to 00:00.00,
// then blinks led_done until acknowledged or reloaded.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int TICK_DIV    = TICK_DIV_50M,
   parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
   input logic              CLOCK_50,
   input logic              key_reset,
   countdown_timer_if.slave bus
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

   timer_state_t        state;
   logic [PRESC_W-1:0]  prescaler;
   logic [BLINK_W-1:0]  blink_cnt;
   logic                led_running_q;
   logic                led_done_q;
   logic                done_pulse_q;

   // Index 0 = centisecond units ... index 5 = minute tens.
   bcd_digit_t [5:0]    digit;
   bcd_digit_t [5:0]    load_val;
   logic                tick;
   logic                count_zero;
   logic                run_dec;
   logic                reach_zero;
   logic                load_cmd;
   logic                underflow;

   assign tick       = ((state == RUN) || (state == DONE)) && (prescaler == PRESC_LAST);
   assign count_zero = (digit == '0);
   assign run_dec    = (state == RUN) && tick && !count_zero;
   assign reach_zero = run_dec && (digit == 24'd1);
   assign load_cmd   = bus.key_load && (state != RUN);

   assign load_val = {clamp_digit(bus.preset_min[7:4], 4'd5),
                      clamp_digit(bus.preset_min[3:0], 4'd9),
                      clamp_digit(bus.preset_sec[7:4], 4'd5),
                      clamp_digit(bus.preset_sec[3:0], 4'd9),
                      4'd0,
                      4'd0};

   for (genvar i = 0; i < 6; i++) begin : g_digit
      localparam bcd_digit_t MAX_VAL = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
      logic dec_i;
      logic borrow_i;

      if (i == 0) begin : g_first
         assign dec_i = run_dec;
      end else begin : g_chain
         assign dec_i = g_digit[i-1].borrow_i;
      end

      bcd_digit_down u_digit (
         .CLOCK_50  (CLOCK_50),
         .key_reset (key_reset),
         .load      (load_cmd),
         .load_val  (load_val[i]),
         .dec       (dec_i),
         .max_val   (MAX_VAL),
         .digit     (digit[i]),
         .borrow    (borrow_i)
      );
   end

   assign underflow = g_digit[5].borrow_i;

   always_ff @(posedge CLOCK_50) begin
      if (key_reset) begin
         state         <= IDLE;
         prescaler     <= '0;
         blink_cnt     <= '0;
         led_running_q <= 1'b0;
         led_done_q    <= 1'b0;
         done_pulse_q  <= 1'b0;
      end else begin
         done_pulse_q <= 1'b0;
         if (load_cmd) begin
            state         <= IDLE;
            prescaler     <= '0;
            blink_cnt     <= '0;
            led_running_q <= 1'b0;
            led_done_q    <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.key_start_pause && !count_zero) begin
                     state         <= RUN;
                     prescaler     <= '0;
                     led_running_q <= 1'b1;
                  end
               end
               RUN: begin
                  prescaler <= tick ? '0 : prescaler + PRESC_W'(1);
                  // Reaching zero outranks a coincident pause request.
                  if (reach_zero) begin
                     state         <= DONE;
                     prescaler     <= '0;
                     blink_cnt     <= '0;
                     led_running_q <= 1'b0;
                     led_done_q    <= 1'b1;
                     done_pulse_q  <= 1'b1;
                  end else if (bus.key_start_pause) begin
                     state         <= PAUSE;
                     led_running_q <= 1'b0;
                  end
               end
               PAUSE: begin
                  if (bus.key_start_pause) begin
                     state         <= RUN;
                     led_running_q <= 1'b1;
                  end
               end
               DONE: begin
                  if (bus.key_start_pause) begin
                     state      <= IDLE;
                     prescaler  <= '0;
                     blink_cnt  <= '0;
                     led_done_q <= 1'b0;
                  end else begin
                     prescaler <= tick ? '0 : prescaler + PRESC_W'(1);
                     if (tick) begin
                        if (blink_cnt == BLINK_LAST) begin
                           blink_cnt  <= '0;
                           led_done_q <= ~led_done_q;
                        end else begin
                           blink_cnt <= blink_cnt + BLINK_W'(1);
                        end
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.hex5        = sevenseg(digit[5]);
   assign bus.hex4        = sevenseg(digit[4]);
   assign bus.hex3        = sevenseg(digit[3]);
   assign bus.hex2        = sevenseg(digit[2]);
   assign bus.hex1        = sevenseg(digit[1]);
   assign bus.hex0        = sevenseg(digit[0]);
   assign bus.led_running = led_running_q;
   assign bus.led_done    = led_done_q;
   assign bus.done_pulse  = done_pulse_q;

   // The count must never be decremented past 00:00.00.
   assert property (@(posedge CLOCK_50) disable iff (key_reset) !underflow);

endmodule
